// File: rtl/checkers_link_pkg.sv
// Shared definitions for the inter-board checkers link (transmitter and receiver).
package checkers_link_pkg;

  localparam int unsigned BOARD_W = 256;
  localparam int unsigned ROW_W   = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    SHIFT      = 2'd2,
    FINISH     = 2'd3
  } link_state_e;

endpackage

// File: rtl/sync_ff.sv
// Async-reset flop chain bringing an asynchronous input into the clk domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/board_serial_tx.sv
// Transmit end of the checkers link: shifts one board image out MSB first on a
// generated ser_clk/ser_data pair once the peer receiver reports ready.
module board_serial_tx
  import checkers_link_pkg::*;
#(
  parameter int unsigned DATA_W      = BOARD_W,
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              peer_ready,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              busy,
  output logic              done,
  output logic              abort
);

  localparam int unsigned PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned BC_W = $clog2(DATA_W + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  link_state_e       state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [PH_W-1:0]   phase, phase_d;
  logic [BC_W-1:0]   bitcnt, bitcnt_d;
  logic              ser_clk_d, ser_data_d, busy_d, done_d, abort_d;
  logic              rdy_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d   (peer_ready),
    .q   (rdy_s)
  );

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      phase    <= '0;
      bitcnt   <= '0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      phase    <= phase_d;
      bitcnt   <= bitcnt_d;
      ser_clk  <= ser_clk_d;
      ser_data <= ser_data_d;
      busy     <= busy_d;
      done     <= done_d;
      abort    <= abort_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    phase_d    = phase;
    bitcnt_d   = bitcnt;
    ser_clk_d  = ser_clk;
    ser_data_d = ser_data;
    busy_d     = busy;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    unique case (state)
      IDLE: begin
        ser_clk_d  = 1'b0;
        ser_data_d = 1'b0;
        busy_d     = 1'b0;
        if (start) begin
          shreg_d  = tx_data;
          phase_d  = '0;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = WAIT_READY;
        end
      end

      WAIT_READY: begin
        ser_clk_d  = 1'b0;
        ser_data_d = 1'b0;
        if (rdy_s) begin
          phase_d    = '0;
          bitcnt_d   = '0;
          ser_data_d = shreg[DATA_W-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (!rdy_s) begin
          // Peer withdrew mid-frame: drop the frame and let software retry
          ser_clk_d  = 1'b0;
          ser_data_d = 1'b0;
          busy_d     = 1'b0;
          abort_d    = 1'b1;
          state_d    = IDLE;
        end else if (phase != PH_LAST) begin
          phase_d = phase + PH_W'(1);
        end else begin
          phase_d = '0;
          if (!ser_clk) begin
            ser_clk_d = 1'b1;
          end else begin
            ser_clk_d = 1'b0;
            bitcnt_d  = bitcnt + BC_W'(1);
            if (bitcnt == BC_LAST) begin
              ser_data_d = 1'b0;
              done_d     = 1'b1;
              state_d    = FINISH;
            end else begin
              shreg_d    = {shreg[DATA_W-2:0], 1'b0};
              ser_data_d = shreg[DATA_W-2];
            end
          end
        end
      end

      FINISH: begin
        ser_clk_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_serial_tx.sv
// Bench for board_serial_tx: small (8-bit) and full-size (256-bit) instances.
module tb_board_serial_tx;

  localparam int HP8  = 2;
  localparam int HP256 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, peer8 = 1'b1;
  logic [7:0]  tx8 = '0;
  logic        sclk8, sdat8, busy8, done8, abort8;
  logic        start256 = 1'b0, peer256 = 1'b1;
  logic [255:0] tx256 = '0;
  logic        sclk256, sdat256, busy256, done256, abort256;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  board_serial_tx #(.DATA_W(8), .HALF_PERIOD(HP8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .peer_ready(peer8),
    .ser_clk(sclk8), .ser_data(sdat8), .busy(busy8), .done(done8), .abort(abort8)
  );

  board_serial_tx dut256 (
    .clk(clk), .rst(rst), .start(start256), .tx_data(tx256), .peer_ready(peer256),
    .ser_clk(sclk256), .ser_data(sdat256), .busy(busy256), .done(done256), .abort(abort256)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Link-level observer: a receiver samples ser_data on each ser_clk rise
  bit  bits8[$];
  int  rise8[$], doneq8[$], abortq8[$];
  logic prev_clk8 = 1'b0, prev_dat8 = 1'b0;
  int  stab_viol8 = 0, excl_viol8 = 0;

  always @(negedge clk) begin
    if (sclk8 && !prev_clk8) begin
      bits8.push_back(sdat8);
      rise8.push_back(cyc);
    end
    if (sclk8 && prev_clk8 && sdat8 !== prev_dat8) stab_viol8++;
    if (done8)  doneq8.push_back(cyc);
    if (abort8) abortq8.push_back(cyc);
    if (done8 && abort8) excl_viol8++;
    prev_clk8 = sclk8;
    prev_dat8 = sdat8;
  end

  bit  bits256[$];
  int  rise256[$], doneq256[$];
  logic prev_clk256 = 1'b0;

  always @(negedge clk) begin
    if (sclk256 && !prev_clk256) begin
      bits256.push_back(sdat256);
      rise256.push_back(cyc);
    end
    if (done256) doneq256.push_back(cyc);
    prev_clk256 = sclk256;
  end

  task automatic pulse_start8(input logic [7:0] d, output int acc);
    @(posedge clk); #1;
    start8 = 1'b1;
    tx8    = d;
    @(posedge clk); #1;
    acc    = cyc;
    start8 = 1'b0;
    tx8    = 8'($urandom);
  endtask

  task automatic wait_end8(input int d0, input int a0, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (doneq8.size() > d0 || abortq8.size() > a0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rises8(input int target, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rise8.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected: 8 bits MSB first, rises 2*HP apart, SHIFT spans 2*HP*8 cycles
  task automatic check_frame8(input string tag, input logic [7:0] exp, input int b0, input int d0);
    logic [7:0] got;
    int bad;
    got = '0;
    bad = 0;
    check({tag, " nbits"}, bits8.size() - b0, 8);
    if (bits8.size() >= b0 + 8) begin
      for (int i = 0; i < 8; i++) got[7-i] = bits8[b0+i];
      for (int i = 1; i < 8; i++) if (rise8[b0+i] - rise8[b0+i-1] != 2*HP8) bad++;
    end
    check({tag, " frame"}, got, exp);
    check({tag, " spacing"}, bad, 0);
    if (doneq8.size() > d0 && rise8.size() > b0)
      check({tag, " shift len"}, doneq8[d0] - (rise8[b0] - HP8), 2*HP8*8);
  endtask

  task automatic send8(input string tag, input logic [7:0] d);
    int b0, d0, a0, acc;
    logic ok;
    b0 = bits8.size(); d0 = doneq8.size(); a0 = abortq8.size();
    pulse_start8(d, acc);
    wait_end8(d0, a0, 400, ok);
    check({tag, " ended"}, ok, 1'b1);
    check({tag, " no abort"}, abortq8.size() - a0, 0);
    check({tag, " done+busy"}, {busy8, done8}, 2'b11);
    if (rise8.size() > b0) check({tag, " first rise"}, rise8[b0] - acc, 1 + HP8);
    check_frame8(tag, d, b0, d0);
    @(posedge clk); #1;
    check({tag, " idle after"}, {busy8, done8, sclk8, sdat8}, 4'b0000);
  endtask

  initial begin
    int b0, d0, a0, acc, c;
    logic ok;
    logic [7:0] d;
    logic [255:0] frame, got256;

    #3;
    check("reset outs8", {sclk8, sdat8, busy8, done8, abort8}, 5'b0);
    check("reset outs256", {sclk256, sdat256, busy256, done256, abort256}, 5'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    send8("a5", 8'hA5);

    // Peer not ready: transmitter must hold in wait without clocking
    @(posedge clk); #1;
    peer8 = 1'b0;
    repeat (4) @(posedge clk); #1;
    b0 = bits8.size(); d0 = doneq8.size(); a0 = abortq8.size();
    pulse_start8(8'h3C, acc);
    repeat (50) @(posedge clk); #1;
    check("wait busy", busy8, 1'b1);
    check("wait no sclk", rise8.size() - b0, 0);
    check("wait no abort", abortq8.size() - a0, 0);
    peer8 = 1'b1;
    c = cyc;
    wait_end8(d0, a0, 400, ok);
    check("3c ended", ok, 1'b1);
    if (rise8.size() > b0) check("3c sync latency", rise8[b0] - c, 3 + HP8);
    check_frame8("3c", 8'h3C, b0, d0);
    repeat (3) @(posedge clk);

    // Peer drops after the third bit
    b0 = bits8.size(); d0 = doneq8.size(); a0 = abortq8.size();
    pulse_start8(8'($urandom), acc);
    wait_rises8(b0 + 3, ok);
    check("abort reach bit3", ok, 1'b1);
    @(posedge clk); #1;
    peer8 = 1'b0;
    c = cyc;
    wait_end8(d0, a0, 100, ok);
    check("abort seen", ok, 1'b1);
    check("abort outs", {sclk8, sdat8, busy8, abort8}, 4'b0001);
    if (abortq8.size() > a0) check("abort timing", abortq8[a0] - c, 3);
    repeat (40) @(posedge clk); #1;
    check("abort once", abortq8.size() - a0, 1);
    check("abort no done", doneq8.size() - d0, 0);
    check("abort bits", bits8.size() - b0 < 8, 1'b1);
    peer8 = 1'b1;
    repeat (4) @(posedge clk);
    send8("ff", 8'hFF);

    // Restart while busy is ignored; start coincident with done is ignored
    b0 = bits8.size(); d0 = doneq8.size(); a0 = abortq8.size();
    pulse_start8(8'hA5, acc);
    wait_rises8(b0 + 2, ok);
    pulse_start8(8'h00, c);
    wait_end8(d0, a0, 400, ok);
    check("restart ended", ok, 1'b1);
    check_frame8("restart", 8'hA5, b0, d0);
    start8 = 1'b1;
    tx8 = 8'h5A;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("start@done ignored", busy8, 1'b0);
    repeat (60) @(posedge clk); #1;
    check("restart one done", doneq8.size() - d0, 1);
    check("restart bit total", bits8.size() - b0, 8);

    // Asynchronous reset while the fifth bit is clocked high
    d = 8'($urandom) | 8'h08;
    b0 = bits8.size(); d0 = doneq8.size(); a0 = abortq8.size();
    pulse_start8(d, acc);
    wait_rises8(b0 + 5, ok);
    check("rst pre state", {sclk8, sdat8, busy8}, 3'b111);
    #1 rst = 1'b1;
    #1 check("rst async outs", {sclk8, sdat8, busy8, done8, abort8}, 5'b0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("rst idle", {busy8, sclk8}, 2'b00);
    check("rst no done", doneq8.size() - d0, 0);
    send8("post rst", 8'($urandom));

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send8($sformatf("rand%0d", k), 8'($urandom));
    end

    // Full-size board image, row8 in the MSBs
    for (int r = 0; r < 8; r++) frame[r*32 +: 32] = $urandom;
    frame[255:224] = 32'h30303030;
    frame[31:0]    = 32'h01010101;
    b0 = bits256.size(); d0 = doneq256.size();
    @(posedge clk); #1;
    start256 = 1'b1;
    tx256 = frame;
    @(posedge clk); #1;
    acc = cyc;
    start256 = 1'b0;
    tx256 = {8{32'($urandom)}};
    ok = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk); #1;
      if (doneq256.size() > d0) begin
        ok = 1'b1;
        break;
      end
    end
    check("b256 ended", ok, 1'b1);
    check("b256 nbits", bits256.size() - b0, 256);
    got256 = '0;
    if (bits256.size() >= b0 + 256)
      for (int i = 0; i < 256; i++) got256[255-i] = bits256[b0+i];
    check("b256 frame", got256, frame);
    if (rise256.size() > b0) begin
      check("b256 first rise", rise256[b0] - acc, 1 + HP256);
      if (doneq256.size() > d0)
        check("b256 shift len", doneq256[d0] - (rise256[b0] - HP256), 2048);
    end
    @(posedge clk); #1;
    check("b256 idle after", {busy256, done256, sclk256}, 3'b000);

    check("data stable", stab_viol8, 0);
    check("done/abort excl", excl_viol8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
